// File: rtl/key_debouncer_if.sv
// Key conditioner bus: raw key pins in, debounced level and press/release
// strobes out. The conditioner is the slave; whoever owns the pins is the master.
interface key_debouncer_if #(
  parameter int N_KEYS = 3
);
  logic [N_KEYS-1:0] key_in;
  logic [N_KEYS-1:0] key_level;
  logic [N_KEYS-1:0] key_press;
  logic [N_KEYS-1:0] key_release;

  modport master (
    output key_in,
    input  key_level,
    input  key_press,
    input  key_release
  );

  modport slave (
    input  key_in,
    output key_level,
    output key_press,
    output key_release
  );
endinterface

// File: rtl/key_debouncer.sv
// Multi-channel push-button conditioner. Each key is polarity-normalized,
// brought into the clk domain with two flops, and filtered by its own
// four-state FSM. A change is accepted only after DEBOUNCE_CYCLES consecutive
// agreeing samples. The accepted level and one-cycle press/release strobes
// all leave the block from flops, so downstream logic can use the strobes as
// clean enables instead of wiring keys to clock pins.
module key_debouncer #(
  parameter int N_KEYS          = 3,
  parameter int DEBOUNCE_CYCLES = 2_000_000,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  key_debouncer_if.slave bus
);

  // The counter only ever has to reach DEBOUNCE_CYCLES, so this width is enough.
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] TARGET = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] ONE    = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  logic [N_KEYS-1:0] raw_n;
  logic [N_KEYS-1:0] sync_q1;
  logic [N_KEYS-1:0] sync_q2;

  // After normalization, 1 always means "pressed" whatever the board wiring.
  assign raw_n = ACTIVE_LOW ? ~bus.key_in : bus.key_in;

  // Two-flop synchronizer; reset value is "not pressed" in normalized terms.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= raw_n;
      sync_q2 <= sync_q1;
    end
  end

  for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [CW-1:0] cnt_inc;
    logic          level_r;
    logic          level_next;
    logic          press_r;
    logic          press_next;
    logic          release_r;
    logic          release_next;
    logic          s;

    assign s       = sync_q2[i];
    assign cnt_inc = cnt + ONE;

    // Channel state, counter and registered outputs; reset drops strobes at once.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state     <= IDLE;
        cnt       <= '0;
        level_r   <= 1'b0;
        press_r   <= 1'b0;
        release_r <= 1'b0;
      end else begin
        state     <= state_next;
        cnt       <= cnt_next;
        level_r   <= level_next;
        press_r   <= press_next;
        release_r <= release_next;
      end
    end

    // Debounce decisions: any opposite sample restarts, the Nth agreeing sample commits.
    always_comb begin
      state_next   = state;
      cnt_next     = cnt;
      level_next   = level_r;
      press_next   = 1'b0;
      release_next = 1'b0;

      case (state)
        IDLE: begin
          cnt_next = '0;
          if (s) begin
            if (ONE == TARGET) begin
              state_next = PRESSED;
              level_next = 1'b1;
              press_next = 1'b1;
            end else begin
              state_next = PRESS_WAIT;
              cnt_next   = ONE;
            end
          end
        end

        PRESS_WAIT: begin
          if (!s) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else if (cnt_inc == TARGET) begin
            state_next = PRESSED;
            cnt_next   = '0;
            level_next = 1'b1;
            press_next = 1'b1;
          end else begin
            cnt_next = cnt_inc;
          end
        end

        PRESSED: begin
          cnt_next = '0;
          if (!s) begin
            if (ONE == TARGET) begin
              state_next   = IDLE;
              level_next   = 1'b0;
              release_next = 1'b1;
            end else begin
              state_next = RELEASE_WAIT;
              cnt_next   = ONE;
            end
          end
        end

        RELEASE_WAIT: begin
          if (s) begin
            state_next = PRESSED;
            cnt_next   = '0;
          end else if (cnt_inc == TARGET) begin
            state_next   = IDLE;
            cnt_next     = '0;
            level_next   = 1'b0;
            release_next = 1'b1;
          end else begin
            cnt_next = cnt_inc;
          end
        end

        default: begin
          state_next = IDLE;
          cnt_next   = '0;
          level_next = 1'b0;
        end
      endcase
    end

    assign bus.key_level[i]   = level_r;
    assign bus.key_press[i]   = press_r;
    assign bus.key_release[i] = release_r;
  end

endmodule
